// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; optional parity bit when UART_RX_PARITY_EN is defined.
// Latency: valid 1 clk after the mid-stop sample (~3 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT from the start edge).
// Backpressure: none; data is held until the next good frame, and pulses last one cycle.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       uart_rx_busy,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_parity_err
);
    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rxd_s_q, rxd_s_d;
    logic          rxd_dly_q, rxd_dly_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
    logic          par_bad_q, par_bad_d;
    logic          fall_edge;
    logic          bit_done;

    assign fall_edge = rxd_dly_q & ~rxd_s_q;
    assign bit_done  = (cnt_q == BIT_LAST);

    always_comb begin
        sync1_d      = uart_rxd;
        rxd_s_d      = sync1_q;
        rxd_dly_d    = rxd_s_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        par_bad_d    = par_bad_q;
        case (state_q)
            S_IDLE: begin
                if (fall_edge) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    idx_d     = '0;
                    par_bad_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    // A start bit that is already high again at mid-bit was a glitch.
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxd_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    par_bad_d = ((^shift_q) ^ rxd_s_q) != PARITY_ODD;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                    busy_d       = 1'b0;
                    frame_err_d  = ~rxd_s_q;
                    parity_err_d = par_bad_q;
                    if (rxd_s_q && !par_bad_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rxd_s_q      <= 1'b1;
            rxd_dly_q    <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rxd_s_q      <= rxd_s_d;
            rxd_dly_q    <= rxd_dly_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            par_bad_q    <= par_bad_d;
        end
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_busy      = busy_q;
    assign uart_rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign uart_rx_parity_err = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity      = parity_err_q ^ PARITY_ODD;
    assign uart_rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 20 clks/bit; pulses are checked against an expected-event queue.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB  = 20;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 3 + (CPB - 1) / 2 + 10 * CPB;
`else
    localparam int LAT = 3 + (CPB - 1) / 2 + 9 * CPB;
`endif

    typedef struct packed {
        logic [2:0] flags;   // {valid, frame_err, parity_err}
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, rx_frame_err, rx_parity_err;

    exp_t exp_q[$];
    exp_t exp_e;
    int   vectors;
    int   miscompares;
    int   cyc;
    int   frame_start_cyc;
    int   last_valid_cyc;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .clk               (clk),
        .reset             (reset),
        .uart_rxd          (rxd),
        .uart_rx_data      (rx_data),
        .uart_rx_valid     (rx_valid),
        .uart_rx_busy      (rx_busy),
        .uart_rx_frame_err (rx_frame_err),
        .uart_rx_parity_err(rx_parity_err)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rx_valid || rx_frame_err || rx_parity_err) begin
            vectors++;
            if (rx_valid) last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got v/fe/pe=%b data=%h, required no pulse",
                         {rx_valid, rx_frame_err, rx_parity_err}, rx_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({rx_valid, rx_frame_err, rx_parity_err} !== exp_e.flags ||
                    (exp_e.flags[2] && rx_data !== exp_e.data)) begin
                    miscompares++;
                    $display("FAIL pulse: got v/fe/pe=%b data=%h, required v/fe/pe=%b data=%h",
                             {rx_valid, rx_frame_err, rx_parity_err}, rx_data, exp_e.flags, exp_e.data);
                end
            end
        end
    end

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Caller is at a negedge; the start bit begins immediately.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`else
        if (par_bit === 1'bz) rxd = 1'b1;
`endif
        drive_bit(stop_bit);
        rxd = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back({3'b100, b});
        send_frame(b, 1'b1, (^b) ^ PODD);
    endtask

    task automatic check_out(input string name, input logic [11:0] required);
        vectors++;
        if ({rx_data, rx_valid, rx_busy, rx_frame_err, rx_parity_err} !== required) begin
            miscompares++;
            $display("FAIL %s: got data/v/busy/fe/pe=%h/%b, required %h/%b", name,
                     rx_data, {rx_valid, rx_busy, rx_frame_err, rx_parity_err},
                     required[11:4], required[3:0]);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: got %0d expected events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rxd   = 1'b1;
        idle_clks(100);
        check_out("reset_state", {8'h00, 4'b0000});
        reset = 1'b1;
        idle_clks(3 * CPB);
        check_out("idle_after_reset", {8'h00, 4'b0000});
    endtask

    task automatic test_single;
        int lat;
        send_good(8'h34);
        idle_clks(5);
        check_drained("single_34");
        check_out("single_34_out", {8'h34, 4'b0000});
        lat = last_valid_cyc - frame_start_cyc;
        vectors++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
            miscompares++;
            $display("FAIL latency: got %0d clks, required %0d +/-2", lat, LAT);
        end
    endtask

    task automatic test_back_to_back;
        send_good(8'h55);
        send_good(8'hA3);
        idle_clks(5);
        check_drained("back_to_back");
        check_out("back_to_back_out", {8'hA3, 4'b0000});
    endtask

    task automatic test_glitch;
        rxd = 1'b0;
        idle_clks(5);
        rxd = 1'b1;
        idle_clks(2 * CPB);
        check_drained("glitch");
        check_out("glitch_out", {8'hA3, 4'b0000});
    endtask

    task automatic test_frame_err;
        exp_q.push_back({3'b010, 8'h00});
        send_frame(8'h0F, 1'b0, (^8'h0F) ^ PODD);
        idle_clks(2 * CPB);
        check_drained("frame_err");
        check_out("frame_err_data_kept", {8'hA3, 4'b0000});
        send_good(8'h12);
        idle_clks(5);
        check_drained("after_frame_err");
        check_out("after_frame_err_out", {8'h12, 4'b0000});
    endtask

    task automatic test_reset_mid;
        rxd = 1'b0;
        idle_clks(CPB);
        rxd = 1'b1;
        idle_clks(4 * CPB + CPB / 2);
        check_out("busy_mid_frame", {8'h12, 4'b0100});
        reset = 1'b0;
        idle_clks(10);
        check_out("reset_mid_frame", {8'h00, 4'b0000});
        reset = 1'b1;
        idle_clks(8 * CPB);
        check_drained("aborted_frame");
        send_good(8'h81);
        idle_clks(5);
        check_drained("after_reset_81");
        check_out("after_reset_81_out", {8'h81, 4'b0000});
    endtask

    task automatic test_break;
        int n;
        exp_q.push_back({3'b010, 8'h00});
        rxd = 1'b0;
        idle_clks(15 * CPB);
        check_drained("break_one_err");
        rxd = 1'b1;
        n = 0;
        while (rx_busy && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check_out("break_idle", {8'h81, 4'b0000});
        idle_clks(2 * CPB);
        send_good(8'h5A);
        idle_clks(5);
        check_drained("after_break");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        exp_q.push_back({3'b100, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1);
        idle_clks(5);
        check_drained("parity_good");
        check_out("parity_good_out", {8'h07, 4'b0000});
        exp_q.push_back({3'b001, 8'h00});
        send_frame(8'h07, 1'b1, 1'b0);
        idle_clks(5);
        check_drained("parity_bad");
        send_good(8'hC4);
        idle_clks(5);
        check_drained("after_parity_bad");
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_break();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        idle_clks(3 * CPB);
        check_drained("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
